// File: rtl/mem_bist_pkg.sv
// Shared types and the expected-data rule for the memory test sequencer.
package mem_bist_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StRead  = 2'd2,
    StDrain = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_CLEAR    = 2'd0,
    MODE_ADDR     = 2'd1,
    MODE_PATTERN  = 2'd2,
    MODE_INV_ADDR = 2'd3
  } mode_t;

  // Expected word for a location; callers truncate the result to their data width.
  function automatic logic [31:0] exp_data(mode_t mode, logic [31:0] addr, logic [31:0] pattern,
                                           int unsigned data_width);
    logic [31:0] mask;
    logic [31:0] value;
    mask = (data_width >= 32) ? '1 : ((32'd1 << data_width) - 32'd1);
    unique case (mode)
      MODE_CLEAR:    value = '0;
      MODE_ADDR:     value = addr;
      MODE_PATTERN:  value = pattern;
      MODE_INV_ADDR: value = ~addr;
    endcase
    return value & mask;
  endfunction

endpackage

// File: rtl/mem_bist_if.sv
// Single-port synchronous memory bus between the sequencer and the memory under test.
interface mem_bist_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  read;
  logic                  write;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (output read, write, addr, data_in, input data_out);
  modport slave  (input read, write, addr, data_in, output data_out);
endinterface

// File: rtl/mem_bist_exp_pipe.sv
// Delay line of {valid, addr, expected} that lines each read up with its returning data.
module mem_bist_exp_pipe #(
  parameter int unsigned STAGES     = 1,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] exp_i,
  output logic                  valid_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] exp_o
);

  logic [STAGES-1:0]     valid_q;
  logic [ADDR_WIDTH-1:0] addr_q [STAGES];
  logic [DATA_WIDTH-1:0] exp_q  [STAGES];

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        addr_q[i] <= '0;
        exp_q[i]  <= '0;
      end
    end else if (flush_i) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= valid_i;
      addr_q[0]  <= addr_i;
      exp_q[0]   <= exp_i;
      for (int i = 1; i < STAGES; i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
        exp_q[i]   <= exp_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[STAGES-1];
  assign addr_o  = addr_q[STAGES-1];
  assign exp_o   = exp_q[STAGES-1];

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory test sequencer: write every location, read it back, count mismatches and
// remember the first failing address.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [31:0] PATTERN    = 32'h0000_00E9,
  parameter int unsigned ERR_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            mode,
  mem_bist_if.master            mem,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic                  fail_valid,
  output logic [ADDR_WIDTH-1:0] fail_addr
);

  state_t                state_q, state_d;
  mode_t                 mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  read_q, read_d, write_q, write_d;
  logic                  busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ERR_WIDTH-1:0]  err_q, err_d;
  logic                  fail_valid_q, fail_valid_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]            drain_q, drain_d;

  logic                  flush, abort_run, mismatch;
  logic                  head_valid;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_exp, rd_exp;

  function automatic logic [DATA_WIDTH-1:0] exp_of(mode_t m, logic [ADDR_WIDTH-1:0] a);
    return DATA_WIDTH'(exp_data(m, 32'(a), PATTERN, DATA_WIDTH));
  endfunction

  // Expected data enters the pipe one edge after the read strobe is presented.
  assign rd_exp = exp_of(mode_q, addr_q);

  mem_bist_exp_pipe #(
    .STAGES    (RD_LATENCY),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_exp_pipe (
    .clk    (clk),
    .rst_   (rst_),
    .flush_i(flush),
    .valid_i(read_q),
    .addr_i (addr_q),
    .exp_i  (rd_exp),
    .valid_o(head_valid),
    .addr_o (head_addr),
    .exp_o  (head_exp)
  );

  // X or Z on the returned data must count as a failure.
  assign mismatch  = head_valid && (mem.data_out !== head_exp);
  assign abort_run = abort && (state_q != StIdle);

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    read_d       = 1'b0;
    write_d      = 1'b0;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_addr_d  = fail_addr_q;
    drain_d      = drain_q;
    flush        = 1'b0;

    if (mismatch && !abort_run) begin
      if (err_q != '1) err_d = err_q + 1'b1;
      if (!fail_valid_q) begin
        fail_valid_d = 1'b1;
        fail_addr_d  = head_addr;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          mode_d       = mode_t'(mode);
          done_d       = 1'b0;
          pass_d       = 1'b0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_addr_d  = '0;
          busy_d       = 1'b1;
          addr_d       = '0;
          write_d      = 1'b1;
          wdata_d      = exp_of(mode_t'(mode), '0);
          state_d      = StWrite;
        end
      end
      StWrite: begin
        if (addr_q == '1) begin
          addr_d  = '0;
          read_d  = 1'b1;
          state_d = StRead;
        end else begin
          addr_d  = addr_q + 1'b1;
          write_d = 1'b1;
          wdata_d = exp_of(mode_q, addr_q + 1'b1);
        end
      end
      StRead: begin
        if (addr_q == '1) begin
          addr_d  = '0;
          drain_d = '0;
          state_d = StDrain;
        end else begin
          addr_d = addr_q + 1'b1;
          read_d = 1'b1;
        end
      end
      StDrain: begin
        if (drain_q == 3'(RD_LATENCY - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
          state_d = StIdle;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
    endcase

    // Results gathered so far survive an abort; only the sequencing is dropped.
    if (abort_run) begin
      state_d = StIdle;
      addr_d  = '0;
      read_d  = 1'b0;
      write_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      flush   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q      <= StIdle;
      mode_q       <= MODE_CLEAR;
      addr_q       <= '0;
      wdata_q      <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_addr_q  <= '0;
      drain_q      <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      read_q       <= read_d;
      write_q      <= write_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_addr_q  <= fail_addr_d;
      drain_q      <= drain_d;
    end
  end

  assign mem.read    = read_q;
  assign mem.write   = write_q;
  assign mem.addr    = addr_q;
  assign mem.data_in = wdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_count   = err_q;
  assign fail_valid  = fail_valid_q;
  assign fail_addr   = fail_addr_q;

endmodule
